// File: rtl/skewed_input_buffer.sv
// skewed_input_buffer: multi-lane vector FIFO whose read side presents each lane
// either aligned or diagonally skewed (lane k delayed k cycles) for a systolic array.
module skewed_input_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_CH       = 4,
  parameter int ADDR_WIDTH   = 2,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH-1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_wr_data,
  input  logic                         i_rd,
  input  logic                         i_skew_en,
  input  logic                         i_flush,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
  output logic [NUM_CH-1:0]            o_valid,
  output logic                         o_is_empty,
  output logic                         o_is_full,
  output logic                         o_almost_full,
  output logic [ADDR_WIDTH:0]          o_count,
  output logic                         o_drained,
  output logic                         o_overflow,
  output logic                         o_underflow
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int W     = NUM_CH*DATA_WIDTH;
  localparam int CW    = ADDR_WIDTH+1;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = CW'(AFULL_THRESH);

  logic [W-1:0]            mem [DEPTH];
  logic [W-1:0]            rd_data;
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic                    pop, push, skew, eff_skew;
  logic [NUM_CH-1:0]       busy;

  assign o_is_empty    = o_count == '0;
  assign o_is_full     = o_count == FULL_CNT;
  assign o_almost_full = o_count >= AF_CNT;
  assign o_drained     = ~|busy;
  assign pop           = i_rd && !o_is_empty && !i_flush;
  assign push          = i_wr && (!o_is_full || pop) && !i_flush;
  assign rd_data       = mem[rd_ptr];
  // Mode follows i_skew_en only while the chains are empty, and the pop of that
  // same cycle is already routed by the new mode so nothing in flight is lost.
  assign eff_skew      = o_drained ? i_skew_en : skew;

  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= i_wr_data;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      skew        <= 1'b0;
    end else begin
      skew <= eff_skew;
      if (i_flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        o_count     <= '0;
        o_overflow  <= 1'b0;
        o_underflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        o_count <= o_count + CW'(push) - CW'(pop);
        if (i_wr && o_is_full && !pop) o_overflow <= 1'b1;
        if (i_rd && o_is_empty) o_underflow <= 1'b1;
      end
    end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in, lane_out, d_q;
    logic                  v_out, v_q;
    assign lane_in = rd_data[k*DATA_WIDTH +: DATA_WIDTH];
    if (k == 0) begin : g_direct
      assign v_out    = pop;
      assign lane_out = lane_in;
      assign busy[k]  = 1'b0;
    end else begin : g_chain
      logic [k-1:0]          cv;
      logic [DATA_WIDTH-1:0] cd [k];
      always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) cv <= '0;
        else if (i_flush) cv <= '0;
        else begin
          cv[0] <= pop && eff_skew;
          for (int j = 1; j < k; j++) cv[j] <= cv[j-1];
        end
      always_ff @(posedge i_clk) begin
        cd[0] <= lane_in;
        for (int j = 1; j < k; j++) cd[j] <= cd[j-1];
      end
      assign busy[k]  = |cv;
      assign v_out    = cv[k-1] | (pop & !eff_skew);
      assign lane_out = cv[k-1] ? cd[k-1] : lane_in;
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (i_flush) v_q <= 1'b0;
      else begin
        v_q <= v_out;
        if (v_out) d_q <= lane_out;
      end
    assign o_valid[k] = v_q;
    assign o_data[k*DATA_WIDTH +: DATA_WIDTH] = d_q;
  end
endmodule

// File: tb/tb_skewed_input_buffer.sv
// tb_skewed_input_buffer: directed checks of the skewed input buffer at default parameters.
module tb_skewed_input_buffer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr = 1'b0, rd = 1'b0, skew_en = 1'b0, flush = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] data;
  logic [3:0]  valid;
  logic        empty, full, afull, drained, ovf, unf;
  logic [2:0]  count;
  int checks = 0, errors = 0;

  skewed_input_buffer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_wr_data(wr_data), .i_rd(rd),
    .i_skew_en(skew_en), .i_flush(flush), .o_data(data), .o_valid(valid),
    .o_is_empty(empty), .o_is_full(full), .o_almost_full(afull), .o_count(count),
    .o_drained(drained), .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, afull, 0);
    chk({tag, "_drained"}, drained, 1);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_unf"}, unf, 0);
  endtask

  function automatic logic [31:0] vec(input int i);
    return 32'(i) * 32'h01010101 + 32'h00010203;
  endfunction

  initial begin
    #12;
    chk_reset("reset");
    rst_n = 1'b1;
    // fill
    wr = 1; wr_data = 32'h44332211; step(); chk("cnt1", count, 1);
    wr_data = 32'h88776655; step(); chk("afull2", afull, 0);
    wr_data = 32'hCCBBAA99; step(); chk("afull3", afull, 1); chk("full3", full, 0);
    wr_data = 32'h00FFEEDD; step(); chk("full4", full, 1); chk("cnt4", count, 4);
    // skewed pop
    wr = 0; skew_en = 1; rd = 1; step();
    chk("sk_v0", valid, 4'b0001); chk("sk_d0", data, 32'h00000011); chk("sk_cnt", count, 3);
    rd = 0; step();
    chk("sk_v1", valid, 4'b0010); chk("sk_d1", data, 32'h00002211); chk("sk_drn", drained, 0);
    step(); chk("sk_v2", valid, 4'b0100); chk("sk_d2", data, 32'h00332211);
    step(); chk("sk_v3", valid, 4'b1000); chk("sk_d3", data, 32'h44332211);
    step(); chk("sk_v4", valid, 4'b0000); chk("sk_drn2", drained, 1);
    // overflow
    wr = 1; wr_data = 32'h55AA55AA; step(); chk("of_full", full, 1);
    wr_data = 32'hDEADBEEF; step(); chk("of_cnt", count, 4); chk("of_flag", ovf, 1);
    skew_en = 0; rd = 1; wr_data = 32'h12345678; step();
    chk("rw_cnt", count, 4); chk("rw_v", valid, 4'hF); chk("rw_d", data, 32'h88776655);
    wr = 0; step(); chk("rd_a", data, 32'hCCBBAA99); chk("rd_av", valid, 4'hF);
    step(); chk("rd_b", data, 32'h00FFEEDD);
    step(); chk("rd_c", data, 32'h55AA55AA);
    step(); chk("rd_last", data, 32'h12345678); chk("rd_lv", valid, 4'hF); chk("rd_empty", empty, 1);
    // underflow
    step(); chk("uf_v", valid, 0); chk("uf_flag", unf, 1); chk("uf_data", data, 32'h12345678);
    rd = 0; flush = 1; step(); chk("fl_unf", unf, 0); chk("fl_ovf", ovf, 0);
    flush = 0; rd = 1; wr = 1; wr_data = 32'hA1B2C3D4; step();
    chk("ufw_cnt", count, 1); chk("ufw_v", valid, 0); chk("ufw_unf", unf, 1);
    wr = 0; step(); chk("ufw_d", data, 32'hA1B2C3D4); chk("ufw_v2", valid, 4'hF); chk("ufw_cnt0", count, 0);
    // wrap
    rd = 0; wr = 1; wr_data = vec(0); step();
    for (int i = 1; i <= 10; i++) begin
      wr_data = vec(i); rd = 1; step();
      chk($sformatf("wrap_d%0d", i), data, vec(i-1));
      chk($sformatf("wrap_c%0d", i), count, 1);
    end
    wr = 0; step(); chk("wrap_last", data, vec(10));
    rd = 0; step(); chk("wrap_idle", valid, 0);
    // mode change mid-stream
    wr = 1;
    wr_data = 32'hA0A1A2A3; step();
    wr_data = 32'hB0B1B2B3; step();
    wr_data = 32'hC0C1C2C3; step();
    wr_data = 32'hD0D1D2D3; step(); chk("md_cnt", count, 4);
    wr = 0; skew_en = 1; rd = 1; step(); chk("md_v1", valid, 4'b0001);
    skew_en = 0; step(); chk("md_v2", valid, 4'b0011); chk("md_drn", drained, 0);
    step(); chk("md_v3", valid, 4'b0111);
    rd = 0; step(); chk("md_v4", valid, 4'b1110);
    step(); chk("md_v5", valid, 4'b1100);
    step(); chk("md_v6", valid, 4'b1000); chk("md_d6", data, 32'hC0C1C2C3); chk("md_drn6", drained, 1);
    rd = 1; step(); chk("md_al_v", valid, 4'hF); chk("md_al_d", data, 32'hD0D1D2D3);
    // flush while lanes drain
    rd = 0; wr = 1;
    wr_data = 32'hE0E1E2E3; step();
    wr_data = 32'hF0F1F2F3; step();
    wr = 0; skew_en = 1; rd = 1; step(); chk("fd_v1", valid, 4'b0001);
    rd = 0; step(); chk("fd_v2", valid, 4'b0010); chk("fd_drn", drained, 0);
    flush = 1; step();
    chk("fd_v", valid, 0); chk("fd_cnt", count, 0); chk("fd_empty", empty, 1);
    chk("fd_drn2", drained, 1); chk("fd_unf", unf, 0); chk("fd_data", data, 32'hD0D1E2E3);
    flush = 0; step(); chk("fd_v_after", valid, 0);
    // async reset mid-burst
    wr = 1;
    wr_data = 32'h11112222; step();
    wr_data = 32'h33334444; step();
    wr = 0; rd = 1; step(); chk("ar_v", valid, 4'b0001);
    #2 rst_n = 0;
    #1 chk_reset("async");
    rd = 0; wr = 1; wr_data = 32'h5A5A5A5A; rst_n = 1;
    step(); chk("ar_first", count, 1); chk("ar_empty", empty, 0);
    wr = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
